fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the PC register and drives instruction-memory requests.
- Consumes the redirect pair (target, enable) that the branch/jump resolution unit produces in EX.
- On a redirect it steers the next fetch and flushes the younger pipeline stages.
- Arbitrates between redirect, load-use stall, and sequential PC+4. Presents a valid-qualified IF/ID payload.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when a slot is flushed or invalid (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_en  in  1  taken branch/jump from EX (PCnewEnable).
- redirect_pc  in  32  redirect target from EX (PCnew).
- stall_i  in  1  load-use hazard: ID must hold its current instruction.
- imem_req  out  1  fetch request; held with imem_addr stable until imem_ready.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  response strobe; imem_rdata valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  IF/ID slot holds a real instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  instruction to ID.
- flush_ifid  out  1  combinational, = redirect_en & ~rst.
- flush_idex  out  1  combinational, = redirect_en & ~rst.
- misalign_err  out  1  registered one-cycle pulse; redirect_pc[1:0] != 0.

Behaviour:
Reset (synchronous, overrides everything):
- pc = RESET_PC, state = FETCH, imem_req = 0, if_valid = 0, if_pc = 0, if_instr = NOP_INSTR, skid empty, misalign_err = 0.
- First imem_req rises in the cycle after rst deasserts.

State FETCH:
- imem_req = 1 when the skid is empty. imem_addr = pc.
- On imem_ready with no stall and no redirect:
  - if_valid/if_pc/if_instr <= 1/pc/imem_rdata.
  - pc <= pc + 4, wrapping modulo 2^32.
- Back-to-back fetches give one instruction per cycle when imem_ready is held high.

Stall (stall_i = 1, redirect_en = 0):
- IF/ID outputs and pc hold.
- A response completing during the stall goes to a 1-entry skid (pc, instr). pc <= pc + 4.
- imem_req drops while the skid is full.
- On stall release, the skid moves to IF/ID that cycle, then fetching resumes.
- There is no bubble when the skid was full.

Redirect (redirect_en = 1; wins over stall and sequential):
- flush_ifid = flush_idex = 1 in the same cycle.
- At the edge: if_valid <= 0, if_instr <= NOP_INSTR, skid cleared.
- Target used is {redirect_pc[31:2], 2'b00}. misalign_err pulses for one cycle if the low bits were non-zero.
- No request outstanding, or imem_ready = 1 this cycle: pc <= target. The response is discarded. State stays FETCH.
- Request outstanding and imem_ready = 0:
  - Target latched into pend_pc. State <= DRAIN.
  - The address must not change mid-request.

State DRAIN:
- imem_req = 1 with the old address.
- On imem_ready: data discarded, pc <= pend_pc, state <= FETCH.
- A second redirect_en in DRAIN overwrites pend_pc (youngest target wins) and flushes again.

Boundaries:
- Redirect and stall in the same cycle: redirect wins, and the stall is ignored that cycle.
- Redirect arriving in the same cycle the skid fills: the skid is cleared.
- pc = 32'hFFFF_FFFC wraps to 0.
- rst asserted in DRAIN abandons the drain.

Decomposition:
- Shared package fetch_pkg:
  - state enum {FETCH, DRAIN}.
  - NOP_INSTR and RESET_PC defaults.
  - PC_STEP = 4.
- One sub-module, fetch_skid: 1-entry (pc, instr) buffer with load/clear/valid.

Test Plan:
- Reset release, imem_ready tied 1 -> imem_addr 0, 4, 8 on consecutive cycles; if_pc 0, 4 with if_valid = 1 one cycle after each request.
- Redirect to 32'h0000_0100 while imem_ready = 1 at pc = 8 -> flush_ifid/flush_idex = 1 that cycle; next imem_addr = 0x100; if_valid = 0 for one cycle.
- Redirect to 0x200 while a request to 0x10 waits 3 cycles -> imem_addr stays 0x10 until ready; that data is not presented; next address is 0x200.
- stall_i high 3 cycles with imem_ready = 1 -> if_pc/if_instr hold; exactly one skid capture; imem_req low while skid full; release -> skid pc appears next, no lost or duplicated PC.
- Redirect 0x0000_0102 -> misalign_err = 1 for one cycle; fetch resumes at 0x100.
- Redirect and stall_i together -> stall ignored; fetch at the target; if_valid = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage sequencer.
package fetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] PC_STEP       = 32'd4;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry (pc, instr) holding buffer used while ID is stalled.
module fetch_skid
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

   // Clear beats load so a redirect always empties the entry.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         instr_d = instr_i;
      end
   end

   // Entry registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
         instr_q <= 32'h0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues imem requests, applies
// redirects/stalls and presents the IF/ID payload.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FETCH | normal sequential fetching; redirect applied immediately
//   DRAIN | redirect arrived mid-request; finish old request, drop data
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        stall_i,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        misalign_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic         misalign_q, misalign_d;

   logic         skid_load, skid_clear, skid_valid;
   logic [31:0]  skid_pc, skid_instr;
   logic         fire;
   logic [31:0]  target;

   fetch_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .pc_i    (pc_q),
      .instr_i (imem_rdata),
      .valid_o (skid_valid),
      .pc_o    (skid_pc),
      .instr_o (skid_instr)
   );

   // Draining must keep the request up; in FETCH a full skid throttles it.
   assign imem_req   = ~rst & ((state_q == DRAIN) | ~skid_valid);
   assign imem_addr  = pc_q;
   assign fire       = imem_req & imem_ready;
   assign target     = align_word(redirect_pc);
   assign flush_ifid = redirect_en & ~rst;
   assign flush_idex = redirect_en & ~rst;

   // Next-state arbitration: redirect > drain > stall > skid replay > fetch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      misalign_d = redirect_en & (redirect_pc[1:0] != 2'b00);
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      if (redirect_en) begin
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
         skid_clear = 1'b1;
         if (!imem_req || imem_ready) begin
            pc_d    = target;
            state_d = FETCH;
         end else begin
            // Address must stay put until the in-flight request completes.
            pend_pc_d = target;
            state_d   = DRAIN;
         end
      end else if (state_q == DRAIN) begin
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
         if (imem_ready) begin
            pc_d    = pend_pc_q;
            state_d = FETCH;
         end
      end else if (stall_i) begin
         if (fire) begin
            skid_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
         end
      end else if (skid_valid) begin
         if_valid_d = 1'b1;
         if_pc_d    = skid_pc;
         if_instr_d = skid_instr;
         skid_clear = 1'b1;
      end else if (fire) begin
         if_valid_d = 1'b1;
         if_pc_d    = pc_q;
         if_instr_d = imem_rdata;
         pc_d       = pc_q + PC_STEP;
      end else begin
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
      end
   end

   // State and payload registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         pend_pc_q  <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0;
         if_instr_q <= NOP_INSTR;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         misalign_q <= misalign_d;
      end
   end

   assign if_valid     = if_valid_q;
   assign if_pc        = if_pc_q;
   assign if_instr     = if_instr_q;
   assign misalign_err = misalign_q;

endmodule
